// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned MUL (shift-add) and DIV (restoring).
// Define MULDIV_EARLY_DZ_EN to finish DIV-by-zero without iterating.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               op_div_q, op_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;
`ifdef MULDIV_EARLY_DZ_EN
    logic               pend_q, pend_d;
`endif

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_mul;
    logic [WIDTH:0]     part;
    logic               ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] acc_div;

    // opb_q holds the multiplicand (MUL) or divisor (DIV)
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_mul = {mul_sum, acc_q[WIDTH-1:1]};
        // shifted remainder needs one extra bit before the trial subtract
        part    = acc_q[2*WIDTH-1:WIDTH-1];
        ge      = part >= {1'b0, opb_q};
        rem_new = part[WIDTH-1:0] - opb_q;
        acc_div = ge ? {rem_new, acc_q[WIDTH-2:0], 1'b1}
                     : {acc_q[2*WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        op_div_d   = op_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
`ifdef MULDIV_EARLY_DZ_EN
        pend_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
`ifdef MULDIV_EARLY_DZ_EN
                if (pend_q) begin
                    state_d    = DONE;
                    hi_d       = acc_q[WIDTH-1:0];
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                end else
`endif
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    op_div_d = op_div;
                    opb_d    = op_div ? data_b : data_a;
                    acc_d    = {{WIDTH{1'b0}},
                                op_div ? data_a : data_b};
`ifdef MULDIV_EARLY_DZ_EN
                    if (op_div && data_b == '0) begin
                        state_d = IDLE;
                        pend_d  = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d    = DONE;
                    hi_d       = acc_q[2*WIDTH-1:WIDTH];
                    lo_d       = acc_q[WIDTH-1:0];
                    div_zero_d = op_div_q && (opb_q == '0);
                end else begin
                    acc_d = op_div_q ? acc_div : acc_mul;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            op_div_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_EARLY_DZ_EN
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            op_div_q   <= op_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
`ifdef MULDIV_EARLY_DZ_EN
            pend_q     <= pend_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result_hi = hi_q;
    assign result_lo = lo_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit with
// hand-computed results, latencies and reset behaviour.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op_div;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        div_zero;

    int errors = 0;
    int checks = 0;
    int n;

`ifdef MULDIV_EARLY_DZ_EN
    localparam int   DZ_LAT  = 1;
    localparam logic DZ_BUSY = 1'b0;
`else
    localparam int   DZ_LAT  = 33;
    localparam logic DZ_BUSY = 1'b1;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_div    (op_div),
        .data_a    (data_a),
        .data_b    (data_b),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // returns with inputs applied and sampled #1 after accept edge
    task automatic issue(input logic d, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op_div = d;
        data_a = a;
        data_b = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!done && edges <= 100);
    endtask

    task automatic run(input string tag, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz);
        int k;
        issue(d, a, b);
        wait_done(k);
        chk({tag, "_lat"}, 64'(k), 64'(lat));
        chk({tag, "_hi"}, 64'(result_hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(result_lo), 64'(elo));
        chk({tag, "_dz"}, 64'(div_zero), 64'(edz));
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op_div = 1'b0;
        data_a = '0;
        data_b = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(result_hi), 64'(0));
        chk("rst_lo", 64'(result_lo), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // MUL max*max
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulmax_busy", 64'(busy), 64'(1));
        wait_done(n);
        chk("mulmax_lat", 64'(n), 64'(33));
        chk("mulmax_hi", 64'(result_hi), 64'hFFFF_FFFE);
        chk("mulmax_lo", 64'(result_lo), 64'h1);
        chk("mulmax_dz", 64'(div_zero), 64'(0));
        chk("mulmax_busy_done", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done), 64'(0));
        chk("hold_hi", 64'(result_hi), 64'hFFFF_FFFE);

        // DIV 100/7 with an ignored start during RUN
        issue(1'b1, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        op_div = 1'b0;
        data_a = 32'd3;
        data_b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("div100_lat", 64'(n + 5), 64'(33));
        chk("div100_lo", 64'(result_lo), 64'd14);
        chk("div100_hi", 64'(result_hi), 64'd2);
        chk("div100_dz", 64'(div_zero), 64'(0));

        // DIV by zero
        issue(1'b1, 32'h1234_5678, 32'h0);
        chk("dz_busy", 64'(busy), 64'(DZ_BUSY));
        wait_done(n);
        chk("dz_lat", 64'(n), 64'(DZ_LAT));
        chk("dz_lo", 64'(result_lo), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(result_hi), 64'h1234_5678);
        chk("dz_flag", 64'(div_zero), 64'(1));

        // wide-remainder divides
        run("divbig", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001,
            33, 32'h7FFF_FFFE, 32'h1, 1'b0);
        run("divsmall", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            33, 32'h8000_0000, 32'h0, 1'b0);
        run("div1", 1'b1, 32'hFFFF_FFFF, 32'h1,
            33, 32'h0, 32'hFFFF_FFFF, 1'b0);

        // back-to-back: MUL 3*5 then DIV 9/2 issued in DONE
        issue(1'b0, 32'd3, 32'd5);
        wait_done(n);
        chk("b2b_mul_lat", 64'(n), 64'(33));
        chk("b2b_mul_lo", 64'(result_lo), 64'd15);
        start  = 1'b1;
        op_div = 1'b1;
        data_a = 32'd9;
        data_b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'(1));
        chk("b2b_done_low", 64'(done), 64'(0));
        chk("b2b_hold_lo", 64'(result_lo), 64'd15);
        wait_done(n);
        chk("b2b_div_lat", 64'(n), 64'(33));
        chk("b2b_div_lo", 64'(result_lo), 64'd4);
        chk("b2b_div_hi", 64'(result_hi), 64'd1);
        chk("b2b_div_dz", 64'(div_zero), 64'(0));

        // reset during RUN of MUL 6*7
        issue(1'b0, 32'd6, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        chk("abort_busy_pre", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_hi", 64'(result_hi), 64'(0));
        chk("abort_lo", 64'(result_lo), 64'(0));
        chk("abort_dz", 64'(div_zero), 64'(0));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
            if (i == 2) reset = 1'b1;
        end
        chk("abort_no_done", 64'(n), 64'(0));
        run("mul42", 1'b0, 32'd6, 32'd7,
            33, 32'h0, 32'd42, 1'b0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
